gmii2xgmii: RTL

GMII2XGMII -- requirements
Module: gmii2xgmii

---
 rtl/gmii2xgmii.sv | 110 +++++++++++
 1 files changed

// File: rtl/gmii2xgmii.sv
// GMII byte stream to 64-bit XGMII word packer. It inserts Start (FB), Error (FE),
// Terminate (FD) and Idle (07) control characters and counts terminated frames.
module gmii2xgmii #(
  parameter int CNT_W = 16
) (
  input  logic             xgmii_clk,
  input  logic             sys_rst_n,
  input  logic             gmii_dv,
  input  logic             gmii_en,
  input  logic             gmii_er,
  input  logic [7:0]       gmii_rxd,
  output logic             xgmii_wr_en,
  output logic [7:0]       xgmii_rxc,
  output logic [63:0]      xgmii_rxd,
  output logic             frame_end,
  output logic [CNT_W-1:0] frame_count,
  output logic             dbg_state
);

  // Handshake: a byte is consumed on every rising edge with gmii_dv=1 (no
  // backpressure). A word is valid on xgmii_rxc/xgmii_rxd only while
  // xgmii_wr_en=1, which lasts exactly one cycle.

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  col, col_nxt;
  logic [7:0]  acc_c, acc_c_nxt;
  logic [63:0] acc_d, acc_d_nxt;
  logic        emit;
  logic        term;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    acc_c_nxt = acc_c;
    acc_d_nxt = acc_d;
    emit      = 1'b0;
    term      = 1'b0;
    if (gmii_dv) begin
      case (state)
        IDLE: begin
          // The first preamble byte is replaced by the Start character.
          if (gmii_en) begin
            acc_c_nxt[0]   = 1'b1;
            acc_d_nxt[7:0] = 8'hFB;
            col_nxt        = 3'd1;
            state_nxt      = DATA;
          end
        end
        DATA: begin
          if (gmii_en) begin
            acc_c_nxt[col]              = gmii_er;
            acc_d_nxt[{col, 3'b000} +: 8] = gmii_er ? 8'hFE : gmii_rxd;
            col_nxt                     = col + 3'd1;
            emit                        = (col == 3'd7);
          end else begin
            // Terminate in the current lane, pad the rest of the word with Idles.
            for (int k = 0; k < 8; k++) begin
              if (3'(k) == col) begin
                acc_c_nxt[k]         = 1'b1;
                acc_d_nxt[k*8 +: 8] = 8'hFD;
              end else if (3'(k) > col) begin
                acc_c_nxt[k]         = 1'b1;
                acc_d_nxt[k*8 +: 8] = 8'h07;
              end
            end
            emit      = 1'b1;
            term      = 1'b1;
            col_nxt   = 3'd0;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge xgmii_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      col         <= 3'd0;
      acc_c       <= 8'hff;
      acc_d       <= 64'h0707070707070707;
      xgmii_wr_en <= 1'b0;
      frame_end   <= 1'b0;
      frame_count <= '0;
      xgmii_rxc   <= 8'hff;
      xgmii_rxd   <= 64'h0707070707070707;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      acc_c       <= acc_c_nxt;
      acc_d       <= acc_d_nxt;
      xgmii_wr_en <= emit;
      frame_end   <= term;
      if (emit) begin
        xgmii_rxc <= acc_c_nxt;
        xgmii_rxd <= acc_d_nxt;
      end
      if (term) frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
